// File: rtl/rtl_kernel_1_ctrl_pkg.sv
// Shared constants for the kernel control-register slave: register offsets,
// CTRL/IER bit positions, FSM state encodings and a byte-strobe merge helper.
package rtl_kernel_1_ctrl_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_GIE      = 6'h04;
  localparam logic [5:0] ADDR_IER      = 6'h08;
  localparam logic [5:0] ADDR_ISR      = 6'h0C;
  localparam logic [5:0] ADDR_SCALAR00 = 6'h10;
  localparam logic [5:0] ADDR_A_LO     = 6'h18;
  localparam logic [5:0] ADDR_A_HI     = 6'h1C;
  localparam logic [5:0] ADDR_B_LO     = 6'h24;
  localparam logic [5:0] ADDR_B_HI     = 6'h28;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int CTRL_READY = 3;
  localparam int CTRL_AUTO  = 7;

  localparam int IER_DONE  = 0;
  localparam int IER_READY = 1;

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic       {RDIDLE, RDDATA} rd_state_t;

  // Merge new data into an existing word, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/rtl_kernel_1_ctrl_if.sv
// AXI4-Lite control bus bundle between the host-side master and the
// kernel control-register slave.
interface rtl_kernel_1_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/rtl_kernel_1_ctrl_irq.sv
// Interrupt block: GIE/IER/ISR registers and the registered level interrupt.
// Only instantiated when RTL_KERNEL_1_CTRL_IRQ_EN is defined.
module rtl_kernel_1_ctrl_irq
  import rtl_kernel_1_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [5:0]  wr_addr,
  input  logic [1:0]  wdata,
  input  logic        wstrb0,
  input  logic [5:0]  rd_addr,
  input  logic        ap_done,
  input  logic        ap_ready,
  output logic [31:0] rd_data,
  output logic        interrupt
);
  logic       gie;
  logic [1:0] ier, isr, isr_nxt, pulse;

  assign pulse[IER_DONE]  = ap_done  & ier[IER_DONE];
  assign pulse[IER_READY] = ap_ready & ier[IER_READY];

  // ISR: host write of 1 toggles a bit, an enabled kernel pulse sets it (pulse wins)
  always_comb begin
    isr_nxt = isr;
    if (wr_en && wstrb0 && wr_addr == ADDR_ISR) isr_nxt = isr ^ wdata;
    isr_nxt = isr_nxt | pulse;
  end

  // Register state; interrupt is computed from next ISR so it follows the pulse by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gie       <= 1'b0;
      ier       <= '0;
      isr       <= '0;
      interrupt <= 1'b0;
    end else begin
      if (wr_en && wstrb0 && wr_addr == ADDR_GIE) gie <= wdata[0];
      if (wr_en && wstrb0 && wr_addr == ADDR_IER) ier <= wdata;
      isr       <= isr_nxt;
      interrupt <= gie & (|isr_nxt);
    end
  end

  // Read-back mux for the three interrupt registers
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_GIE: rd_data[0]   = gie;
      ADDR_IER: rd_data[1:0] = ier;
      ADDR_ISR: rd_data[1:0] = isr;
      default:  rd_data      = '0;
    endcase
  end
endmodule

// File: rtl/rtl_kernel_1_ctrl_regs.sv
// AXI4-Lite control slave for the RTL kernel: ap_ctrl_hs handshake, argument
// registers scalar00/A/B and completion status. Optional interrupt logic is
// enabled by defining RTL_KERNEL_1_CTRL_IRQ_EN.
module rtl_kernel_1_ctrl_regs
  import rtl_kernel_1_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  rtl_kernel_1_ctrl_if.slave s_axi_control,
  output logic               interrupt,
  output logic               ap_start,
  input  logic               ap_done,
  input  logic               ap_ready,
  input  logic               ap_idle,
  output logic [31:0]        scalar00,
  output logic [63:0]        A,
  output logic [63:0]        B
);
  wr_state_t wr_state, wr_nxt;
  rd_state_t rd_state, rd_nxt;
  logic [5:0] waddr;
  logic aw_hs, w_hs, ar_hs, ctrl_wr, ctrl_rd;
  logic auto_restart, done_lat, ready_lat;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_nxt, irq_rdata;
  logic unused_addr;

  // Only the low six address bits are decoded
  assign unused_addr = ^{s_axi_control.awaddr[C_S_AXI_ADDR_WIDTH-1:6],
                         s_axi_control.araddr[C_S_AXI_ADDR_WIDTH-1:6]};

  assign s_axi_control.awready = (wr_state == WRIDLE);
  assign s_axi_control.wready  = (wr_state == WRDATA);
  assign s_axi_control.bvalid  = (wr_state == WRRESP);
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = (rd_state == RDIDLE);
  assign s_axi_control.rvalid  = (rd_state == RDDATA);
  assign s_axi_control.rresp   = 2'b00;
  assign s_axi_control.rdata   = rdata_q;

  assign aw_hs   = s_axi_control.awvalid & s_axi_control.awready;
  assign w_hs    = s_axi_control.wvalid  & s_axi_control.wready;
  assign ar_hs   = s_axi_control.arvalid & s_axi_control.arready;
  assign ctrl_wr = w_hs && waddr == ADDR_CTRL && s_axi_control.wstrb[0];
  assign ctrl_rd = ar_hs && s_axi_control.araddr[5:0] == ADDR_CTRL;

  // FSM state registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state <= WRIDLE;
      rd_state <= RDIDLE;
    end else begin
      wr_state <= wr_nxt;
      rd_state <= rd_nxt;
    end
  end

  // Write channel sequencing: address, then data, then response
  always_comb begin
    wr_nxt = wr_state;
    case (wr_state)
      WRIDLE:  if (s_axi_control.awvalid) wr_nxt = WRDATA;
      WRDATA:  if (s_axi_control.wvalid)  wr_nxt = WRRESP;
      WRRESP:  if (s_axi_control.bready)  wr_nxt = WRIDLE;
      default: wr_nxt = WRIDLE;
    endcase
  end

  // Read channel sequencing: address, then data held until accepted
  always_comb begin
    rd_nxt = rd_state;
    case (rd_state)
      RDIDLE:  if (s_axi_control.arvalid) rd_nxt = RDDATA;
      RDDATA:  if (s_axi_control.rready)  rd_nxt = RDIDLE;
      default: rd_nxt = RDIDLE;
    endcase
  end

  // Capture the write address for the data phase
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  waddr <= '0;
    else if (aw_hs) waddr <= s_axi_control.awaddr[5:0];
  end

  // Kernel handshake: host sets ap_start, kernel ready clears it unless auto-restarting
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ap_start     <= 1'b0;
      auto_restart <= 1'b0;
      done_lat     <= 1'b0;
      ready_lat    <= 1'b0;
    end else begin
      if (ctrl_wr && s_axi_control.wdata[CTRL_START]) ap_start <= 1'b1;
      else if (ap_ready && !auto_restart)               ap_start <= 1'b0;
      if (ctrl_wr) auto_restart <= s_axi_control.wdata[CTRL_AUTO];
      // a status pulse in the same cycle as the clearing read keeps the bit set
      if (ap_done)      done_lat  <= 1'b1;
      else if (ctrl_rd) done_lat  <= 1'b0;
      if (ap_ready)     ready_lat <= 1'b1;
      else if (ctrl_rd) ready_lat <= 1'b0;
    end
  end

  // Kernel argument registers, byte-granular
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      scalar00 <= '0;
      A        <= '0;
      B        <= '0;
    end else if (w_hs) begin
      case (waddr)
        ADDR_SCALAR00: scalar00 <= apply_strb(scalar00, s_axi_control.wdata, s_axi_control.wstrb);
        ADDR_A_LO: A[31:0]  <= apply_strb(A[31:0],  s_axi_control.wdata, s_axi_control.wstrb);
        ADDR_A_HI: A[63:32] <= apply_strb(A[63:32], s_axi_control.wdata, s_axi_control.wstrb);
        ADDR_B_LO: B[31:0]  <= apply_strb(B[31:0],  s_axi_control.wdata, s_axi_control.wstrb);
        ADDR_B_HI: B[63:32] <= apply_strb(B[63:32], s_axi_control.wdata, s_axi_control.wstrb);
        default: ;
      endcase
    end
  end

  // Read-data mux; unmapped offsets fall through to the interrupt block (zero when absent)
  always_comb begin
    rdata_nxt = '0;
    case (s_axi_control.araddr[5:0])
      ADDR_CTRL: begin
        rdata_nxt[CTRL_START] = ap_start;
        rdata_nxt[CTRL_DONE]  = done_lat;
        rdata_nxt[CTRL_IDLE]  = ap_idle;
        rdata_nxt[CTRL_READY] = ready_lat;
        rdata_nxt[CTRL_AUTO]  = auto_restart;
      end
      ADDR_SCALAR00: rdata_nxt = scalar00;
      ADDR_A_LO:     rdata_nxt = A[31:0];
      ADDR_A_HI:     rdata_nxt = A[63:32];
      ADDR_B_LO:     rdata_nxt = B[31:0];
      ADDR_B_HI:     rdata_nxt = B[63:32];
      default:       rdata_nxt = irq_rdata;
    endcase
  end

  // Read data is sampled at the address handshake and held through RDDATA
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  rdata_q <= '0;
    else if (ar_hs) rdata_q <= rdata_nxt;
  end

`ifdef RTL_KERNEL_1_CTRL_IRQ_EN
  rtl_kernel_1_ctrl_irq u_irq (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .wr_en     (w_hs),
    .wr_addr   (waddr),
    .wdata     (s_axi_control.wdata[1:0]),
    .wstrb0    (s_axi_control.wstrb[0]),
    .rd_addr   (s_axi_control.araddr[5:0]),
    .ap_done   (ap_done),
    .ap_ready  (ap_ready),
    .rd_data   (irq_rdata),
    .interrupt (interrupt)
  );
`else
  assign irq_rdata = '0;
  assign interrupt = 1'b0;
`endif
endmodule

// File: tb/tb_rtl_kernel_1_ctrl_regs.sv
// Directed + randomized bench for the kernel control-register slave.
module tb_rtl_kernel_1_ctrl_regs;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ap_done = 1'b0, ap_ready = 1'b0, ap_idle = 1'b1;
  logic ap_start, interrupt;
  logic [31:0] scalar00;
  logic [63:0] A, B;
  int n_assert = 0, n_fail = 0;

  rtl_kernel_1_ctrl_if #(.ADDR_W(12), .DATA_W(32)) ifc ();

  rtl_kernel_1_ctrl_regs #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s_axi_control(ifc),
    .interrupt(interrupt), .ap_start(ap_start), .ap_done(ap_done),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .scalar00(scalar00), .A(A), .B(B)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: register file by word index plus kernel-status flags
  logic [31:0] mreg [0:15];
  bit m_start, m_auto, m_done, m_ready;

  function automatic bit arg_off(input logic [5:0] o);
    return (o == 6'h10 || o == 6'h18 || o == 6'h1C || o == 6'h24 || o == 6'h28);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    m_start = 0; m_auto = 0; m_done = 0; m_ready = 0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [5:0] o;
    o = a[5:0];
    if (arg_off(o))
      for (int i = 0; i < 4; i++) if (s[i]) mreg[o[5:2]][8*i +: 8] = d[8*i +: 8];
    if (o == 6'h00 && s[0]) begin
      if (d[0]) m_start = 1;
      m_auto = d[7];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] o);
    if (arg_off(o)) return mreg[o[5:2]];
    if (o == 6'h00) return {24'h0, m_auto, 3'b000, m_ready, ap_idle, m_done, m_start};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_args(input string tag);
    chk({tag, "_scalar00"}, {32'h0, scalar00}, {32'h0, mreg[4]});
    chk({tag, "_A"}, A, {mreg[7], mreg[6]});
    chk({tag, "_B"}, B, {mreg[10], mreg[9]});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_awready"}, ifc.awready, 1);
    chk({tag, "_arready"}, ifc.arready, 1);
    chk({tag, "_wready"},  ifc.wready,  0);
    chk({tag, "_bvalid"},  ifc.bvalid,  0);
    chk({tag, "_rvalid"},  ifc.rvalid,  0);
    chk({tag, "_rdata"},   ifc.rdata,   0);
    chk({tag, "_ap_start"}, ap_start,   0);
    chk({tag, "_interrupt"}, interrupt, 0);
    chk({tag, "_scalar00"}, scalar00, 0);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
  endtask

  // One full write; optionally drives ap_ready in the same cycle as the W handshake
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit rdy_w = 0);
    int n;
    @(negedge ap_clk);
    ifc.awvalid = 1; ifc.awaddr = a;
    n = 0;
    while (ifc.awready !== 1'b1 && n < 20) begin @(negedge ap_clk); n++; end
    chk("aw_timeout", n < 20, 1);
    @(negedge ap_clk);
    ifc.awvalid = 0;
    chk("wready_lat", ifc.wready, 1);
    ifc.wvalid = 1; ifc.wdata = d; ifc.wstrb = s; ap_ready = rdy_w;
    @(negedge ap_clk);
    ifc.wvalid = 0; ap_ready = 0;
    if (rdy_w) begin m_ready = 1; if (!m_auto) m_start = 0; end
    model_write(a, d, s);
    chk("bvalid_lat", ifc.bvalid, 1);
    chk("bresp", ifc.bresp, 0);
    chk("ap_start_lat", ap_start, m_start);
    chk_args("wr");
    ifc.bready = 1;
    @(negedge ap_clk);
    ifc.bready = 0;
    chk("bvalid_clr", ifc.bvalid, 0);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int n;
    @(negedge ap_clk);
    ifc.arvalid = 1; ifc.araddr = a;
    n = 0;
    while (ifc.arready !== 1'b1 && n < 20) begin @(negedge ap_clk); n++; end
    chk("ar_timeout", n < 20, 1);
    @(negedge ap_clk);
    ifc.arvalid = 0;
    chk("rvalid_lat", ifc.rvalid, 1);
    chk("rresp", ifc.rresp, 0);
    d = ifc.rdata;
    @(negedge ap_clk);
    chk("rdata_hold", ifc.rdata, d);
    ifc.rready = 1;
    @(negedge ap_clk);
    ifc.rready = 0;
    chk("rvalid_clr", ifc.rvalid, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, output logic [31:0] d);
    logic [31:0] exp;
    exp = model_read(a[5:0]);
    axi_read(a, d);
    chk(tag, d, exp);
    if (a[5:0] == 6'h00) begin m_done = 0; m_ready = 0; end
  endtask

  task automatic pulse(input bit dn, input bit rd);
    @(negedge ap_clk);
    ap_done = dn; ap_ready = rd;
    @(negedge ap_clk);
    ap_done = 0; ap_ready = 0;
    if (dn) m_done = 1;
    if (rd) begin m_ready = 1; if (!m_auto) m_start = 0; end
  endtask

  logic [5:0] offs [0:9] = '{6'h10, 6'h18, 6'h1C, 6'h24, 6'h28, 6'h14, 6'h20, 6'h2C, 6'h30, 6'h3C};

  initial begin
    logic [31:0] d, exp;
    logic [5:0] hi;
    logic [11:0] a;
    ifc.awvalid = 0; ifc.awaddr = 0; ifc.wvalid = 0; ifc.wdata = 0; ifc.wstrb = 0;
    ifc.bready = 0; ifc.arvalid = 0; ifc.araddr = 0; ifc.rready = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge ap_clk);
    chk_reset_state("rst");
    ap_rst_n = 1;

    // Basic argument writes and readback
    axi_write(12'h010, 32'h1234_5678, 4'hF);
    axi_write(12'h018, 32'hDEAD_BEEF, 4'hF);
    axi_write(12'h01C, 32'h0000_0001, 4'hF);
    chk("scalar00_basic", scalar00, 32'h1234_5678);
    chk("A_basic", A, 64'h1_DEAD_BEEF);
    rd_chk("rd_scalar00", 12'h010, d);
    rd_chk("rd_A_lo", 12'h018, d);
    rd_chk("rd_A_hi", 12'h01C, d);

    // Byte-strobe write
    axi_write(12'h010, 32'h0, 4'hF);
    axi_write(12'h010, 32'hFFFF_FFFF, 4'b0010);
    chk("scalar00_strb", scalar00, 32'h0000_FF00);

    // Randomized argument/unmapped traffic, upper address bits ignored
    for (int i = 0; i < 30; i++) begin
      hi = 6'($urandom_range(0, 63));
      a = {hi, offs[$urandom_range(0, 9)]};
      axi_write(a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 20; i++) begin
      hi = 6'($urandom_range(0, 63));
      a = {hi, offs[$urandom_range(0, 9)]};
      rd_chk("rd_rand", a, d);
    end
    chk_args("rand_end");

    // Start, kernel completes, status clear-on-read
    axi_write(12'h000, 32'h1, 4'h1);
    chk("start_set", ap_start, 1);
    pulse(1, 1);
    chk("start_clr", ap_start, 0);
    rd_chk("ctrl_rd1", 12'h000, d);
    chk("ctrl_nib1", d[3:0], 4'hE);
    rd_chk("ctrl_rd2", 12'h000, d);
    chk("ctrl_nib2", d[3:0], 4'h4);

    // Auto-restart keeps ap_start through ready pulses
    axi_write(12'h000, 32'h81, 4'h1);
    pulse(0, 1);
    pulse(0, 1);
    chk("auto_start", ap_start, 1);
    rd_chk("ctrl_auto", 12'h000, d);
    axi_write(12'h000, 32'h00, 4'h1);
    pulse(0, 1);
    chk("auto_off_clr", ap_start, 0);
    rd_chk("ctrl_auto_off", 12'h000, d);

    // CTRL read accepted in the same cycle as an ap_done pulse
    exp = model_read(6'h00);
    @(negedge ap_clk);
    ifc.arvalid = 1; ifc.araddr = 12'h000; ap_done = 1;
    @(negedge ap_clk);
    ifc.arvalid = 0; ap_done = 0;
    chk("coinc_rvalid", ifc.rvalid, 1);
    chk("coinc_rdata", ifc.rdata, exp);
    ifc.rready = 1;
    @(negedge ap_clk);
    ifc.rready = 0;
    m_done = 1; m_ready = 0;
    rd_chk("coinc_next", 12'h000, d);
    chk("coinc_done_bit", d[1], 1);
    rd_chk("coinc_after", 12'h000, d);

    // Host set and ap_ready in the same cycle: start wins
    axi_write(12'h000, 32'h1, 4'h1, 1);
    chk("set_vs_ready", ap_start, 1);
    pulse(0, 1);
    chk("set_vs_ready_clr", ap_start, 0);
    rd_chk("ctrl_sr", 12'h000, d);

    // CTRL write without wstrb[0] is ignored
    axi_write(12'h000, 32'h81, 4'b1110);
    chk("ctrl_nostrb", ap_start, 0);
    rd_chk("ctrl_nostrb_rd", 12'h000, d);

`ifdef RTL_KERNEL_1_CTRL_IRQ_EN
    axi_write(12'h004, 32'h1, 4'h1);
    axi_write(12'h008, 32'h1, 4'h1);
    axi_read(12'h004, d); chk("gie_rd", d, 1);
    axi_read(12'h008, d); chk("ier_rd", d, 1);
    axi_write(12'h000, 32'h1, 4'h1);
    @(negedge ap_clk);
    ap_done = 1; ap_ready = 1;
    chk("irq_pre", interrupt, 0);
    @(negedge ap_clk);
    ap_done = 0; ap_ready = 0;
    m_done = 1; m_ready = 1; m_start = 0;
    chk("irq_set", interrupt, 1);
    axi_read(12'h00C, d); chk("isr_rd", d, 1);
    axi_write(12'h00C, 32'h1, 4'h1);
    chk("irq_clr", interrupt, 0);
    axi_read(12'h00C, d); chk("isr_clr_rd", d, 0);
    rd_chk("ctrl_irq", 12'h000, d);
`else
    axi_write(12'h004, 32'h1, 4'h1);
    axi_write(12'h008, 32'h3, 4'h1);
    rd_chk("gie_zero", 12'h004, d);
    rd_chk("ier_zero", 12'h008, d);
    axi_write(12'h000, 32'h1, 4'h1);
    pulse(1, 1);
    repeat (2) @(negedge ap_clk);
    chk("irq_tied", interrupt, 0);
    rd_chk("ctrl_noirq", 12'h000, d);
`endif

    // Reset while both channels are mid-transaction
    axi_write(12'h000, 32'h1, 4'h1);
    @(negedge ap_clk);
    ifc.awvalid = 1; ifc.awaddr = 12'h010; ifc.arvalid = 1; ifc.araddr = 12'h010;
    @(negedge ap_clk);
    ifc.awvalid = 0; ifc.arvalid = 0;
    chk("mid_wready", ifc.wready, 1);
    chk("mid_rvalid", ifc.rvalid, 1);
    ap_rst_n = 0;
    #1;
    chk_reset_state("mid_rst");
    @(negedge ap_clk);
    ap_rst_n = 1;
    model_reset();
    repeat (2) @(negedge ap_clk);
    chk("post_rst_bvalid", ifc.bvalid, 0);
    chk("post_rst_rvalid", ifc.rvalid, 0);
    axi_write(12'h024, 32'hCAFE_F00D, 4'hF);
    rd_chk("post_rst_B", 12'h024, d);
    rd_chk("post_rst_ctrl", 12'h000, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
